// File: rtl/anton_neopixel_frame_scheduler_if.sv
// Handshake bundle between the register file / stream logic (master) and the
// NeoPixel frame scheduler (slave).
//   master drives : cmdStart, cmdStop, cmdInit, cmdSwap, cfgLoop, cfgFrames,
//                   streamSyncOf, initSlowDone
//   slave drives  : regCtrlInit, regCtrlRun, initSlow, bufferSel, swapAck,
//                   frameDone, frameCount, busy, errInit
interface anton_neopixel_frame_scheduler_if #(
  parameter int FRAME_BITS = 8
) ();
  logic                  cmdStart;
  logic                  cmdStop;
  logic                  cmdInit;
  logic                  cmdSwap;
  logic                  cfgLoop;
  logic [FRAME_BITS-1:0] cfgFrames;
  logic                  streamSyncOf;
  logic                  initSlowDone;

  logic                  regCtrlInit;
  logic                  regCtrlRun;
  logic                  initSlow;
  logic                  bufferSel;
  logic                  swapAck;
  logic                  frameDone;
  logic [FRAME_BITS-1:0] frameCount;
  logic                  busy;
  logic                  errInit;

  modport master (
    output cmdStart, cmdStop, cmdInit, cmdSwap, cfgLoop, cfgFrames,
           streamSyncOf, initSlowDone,
    input  regCtrlInit, regCtrlRun, initSlow, bufferSel, swapAck,
           frameDone, frameCount, busy, errInit
  );

  modport slave (
    input  cmdStart, cmdStop, cmdInit, cmdSwap, cfgLoop, cfgFrames,
           streamSyncOf, initSlowDone,
    output regCtrlInit, regCtrlRun, initSlow, bufferSel, swapAck,
           frameDone, frameCount, busy, errInit
  );
endinterface

// File: rtl/anton_neopixel_frame_scheduler.sv
// NeoPixel frame scheduler: turns software commands into init/run controls,
// runs the initSlow handshake with a timeout, counts frames and swaps the
// double-buffered pixel RAM page at frame boundaries.
// Ports:
//   clk6_4mhz : stream clock (sole clock)
//   syncReset : synchronous active-high reset
//   sched     : command/config/status bundle (slave modport)
//
// state        | meaning
// -------------+------------------------------------------------------
// S_IDLE       | stream stopped, waiting for cmdStart / cmdInit
// S_INIT_PULSE | one-cycle initSlow pulse to the stream logic
// S_INIT_WAIT  | waiting for initSlowDone, bounded by INIT_TIMEOUT
// S_RUN        | streaming frames, boundaries marked by streamSyncOf
module anton_neopixel_frame_scheduler #(
  parameter int INIT_TIMEOUT = 15,
  parameter int FRAME_BITS   = 8
) (
  input logic                           clk6_4mhz,
  input logic                           syncReset,
  anton_neopixel_frame_scheduler_if.slave sched
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_INIT_PULSE = 2'd1,
    S_INIT_WAIT  = 2'd2,
    S_RUN        = 2'd3
  } state_t;

  // Last counter value before timeout: the wait covers INIT_TIMEOUT samples.
  localparam logic [7:0] TO_LAST = 8'(INIT_TIMEOUT - 1);

  state_t                r_state;
  logic [7:0]            r_timeout_ctr;
  logic                  r_start_pending;
  logic                  r_stop_pending;
  logic                  r_swap_pending;
  logic                  r_reg_ctrl_init;
  logic                  r_reg_ctrl_run;
  logic                  r_init_slow;
  logic                  r_buffer_sel;
  logic                  r_swap_ack;
  logic                  r_frame_done;
  logic [FRAME_BITS-1:0] r_frame_count;
  logic                  r_busy;
  logic                  r_err_init;

  logic                  w_boundary;
  logic                  w_swap_now;
  logic                  w_stop_eff;
  logic                  w_frames_reached;
  logic [FRAME_BITS-1:0] w_count_inc;

  // A cmdInit abort in RUN is not a frame boundary even if sync coincides.
  assign w_boundary  = (r_state == S_RUN) && sched.streamSyncOf && !sched.cmdInit;
  assign w_swap_now  = (r_swap_pending || sched.cmdSwap) &&
                       ((r_state != S_RUN) || w_boundary);
  assign w_stop_eff  = r_stop_pending || sched.cmdStop;
  assign w_count_inc = (r_frame_count == {FRAME_BITS{1'b1}}) ? r_frame_count
                                                             : r_frame_count + 1'b1;
  assign w_frames_reached = !sched.cfgLoop && (sched.cfgFrames != '0) &&
                            (w_count_inc == sched.cfgFrames);

  always_ff @(posedge clk6_4mhz) begin
    if (syncReset) begin
      r_state         <= S_IDLE;
      r_timeout_ctr   <= '0;
      r_start_pending <= 1'b0;
      r_stop_pending  <= 1'b0;
      r_swap_pending  <= 1'b0;
      r_reg_ctrl_init <= 1'b0;
      r_reg_ctrl_run  <= 1'b0;
      r_init_slow     <= 1'b0;
      r_buffer_sel    <= 1'b0;
      r_swap_ack      <= 1'b0;
      r_frame_done    <= 1'b0;
      r_frame_count   <= '0;
      r_busy          <= 1'b0;
      r_err_init      <= 1'b0;
    end else begin
      r_init_slow  <= 1'b0;
      r_frame_done <= 1'b0;
      r_swap_ack   <= 1'b0;

      if (w_swap_now) begin
        r_buffer_sel   <= ~r_buffer_sel;
        r_swap_ack     <= 1'b1;
        r_swap_pending <= 1'b0;
      end else if (sched.cmdSwap) begin
        r_swap_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if ((sched.cmdStart && !sched.cmdStop) || (sched.cmdInit && !sched.cmdStart)) begin
            r_state         <= S_INIT_PULSE;
            r_init_slow     <= 1'b1;
            r_reg_ctrl_init <= 1'b1;
            r_busy          <= 1'b1;
            r_err_init      <= 1'b0;
            r_stop_pending  <= 1'b0;
            r_start_pending <= sched.cmdStart;
            if (sched.cmdStart) r_frame_count <= '0;
          end
        end

        S_INIT_PULSE: begin
          r_state       <= S_INIT_WAIT;
          r_timeout_ctr <= '0;
          if (sched.cmdStop) r_start_pending <= 1'b0;
        end

        S_INIT_WAIT: begin
          if (sched.initSlowDone) begin
            r_start_pending <= 1'b0;
            r_reg_ctrl_init <= 1'b0;
            if (r_start_pending && !sched.cmdStop) begin
              r_state        <= S_RUN;
              r_reg_ctrl_run <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_timeout_ctr == TO_LAST) begin
            r_state         <= S_IDLE;
            r_err_init      <= 1'b1;
            r_reg_ctrl_init <= 1'b0;
            r_busy          <= 1'b0;
            r_start_pending <= 1'b0;
          end else begin
            r_timeout_ctr <= r_timeout_ctr + 8'd1;
            if (sched.cmdStop) r_start_pending <= 1'b0;
          end
        end

        S_RUN: begin
          if (sched.cmdInit) begin
            r_state         <= S_INIT_PULSE;
            r_init_slow     <= 1'b1;
            r_reg_ctrl_init <= 1'b1;
            r_reg_ctrl_run  <= 1'b0;
            r_start_pending <= 1'b0;
            r_stop_pending  <= 1'b0;
            r_err_init      <= 1'b0;
          end else if (sched.streamSyncOf) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= w_count_inc;
            if (w_stop_eff || w_frames_reached) begin
              r_state        <= S_IDLE;
              r_reg_ctrl_run <= 1'b0;
              r_busy         <= 1'b0;
              r_stop_pending <= 1'b0;
            end
          end else if (sched.cmdStop) begin
            r_stop_pending <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sched.regCtrlInit = r_reg_ctrl_init;
  assign sched.regCtrlRun  = r_reg_ctrl_run;
  assign sched.initSlow    = r_init_slow;
  assign sched.bufferSel   = r_buffer_sel;
  assign sched.swapAck     = r_swap_ack;
  assign sched.frameDone   = r_frame_done;
  assign sched.frameCount  = r_frame_count;
  assign sched.busy        = r_busy;
  assign sched.errInit     = r_err_init;

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
module tb_anton_neopixel_frame_scheduler;
  localparam int FB = 8;
  localparam int TO = 15;

  // input encoding {start, stop, init, swap, loop, sync, done}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] START = 7'b1000000;
  localparam logic [6:0] STOP  = 7'b0100000;
  localparam logic [6:0] INIT  = 7'b0010000;
  localparam logic [6:0] SWAP  = 7'b0001000;
  localparam logic [6:0] LOOP  = 7'b0000100;
  localparam logic [6:0] SYNC  = 7'b0000010;
  localparam logic [6:0] DONE  = 7'b0000001;

  logic clk6_4mhz = 1'b0;
  logic syncReset;

  anton_neopixel_frame_scheduler_if #(.FRAME_BITS(FB)) bus ();

  anton_neopixel_frame_scheduler #(.INIT_TIMEOUT(TO), .FRAME_BITS(FB)) dut (
    .clk6_4mhz (clk6_4mhz),
    .syncReset (syncReset),
    .sched     (bus)
  );

  always #5 clk6_4mhz = ~clk6_4mhz;

  // expected output encoding {regCtrlInit, regCtrlRun, initSlow, bufferSel,
  //                           swapAck, frameDone, busy, errInit}
  typedef struct {
    string      name;
    logic [6:0] in;
    logic [7:0] frames;
    logic [7:0] exp;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [7:0] outs();
    return {bus.regCtrlInit, bus.regCtrlRun, bus.initSlow, bus.bufferSel,
            bus.swapAck, bus.frameDone, bus.busy, bus.errInit};
  endfunction

  function automatic void add(string name, logic [6:0] in, logic [7:0] fr,
                              logic [7:0] exp, logic [7:0] cnt);
    vec_t v;
    v.name = name; v.in = in; v.frames = fr; v.exp = exp; v.exp_cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(logic [6:0] in, logic [7:0] fr);
    {bus.cmdStart, bus.cmdStop, bus.cmdInit, bus.cmdSwap,
     bus.cfgLoop, bus.streamSyncOf, bus.initSlowDone} = in;
    bus.cfgFrames = fr;
    @(posedge clk6_4mhz);
    #1;
  endtask

  initial begin
    int n;
    int pulses;
    int ran;

    // T1: three-frame run
    add("t1_start",      START,        3, 8'b1010_0010, 0);
    add("t1_pulse_end",  NONE,         3, 8'b1000_0010, 0);
    add("t1_wait",       NONE,         3, 8'b1000_0010, 0);
    add("t1_done_run",   DONE,         3, 8'b0100_0010, 0);
    add("t1_sync1",      SYNC,         3, 8'b0100_0110, 1);
    add("t1_gap",        NONE,         3, 8'b0100_0010, 1);
    add("t1_sync2",      SYNC,         3, 8'b0100_0110, 2);
    add("t1_sync3_exit", SYNC,         3, 8'b0000_0100, 3);
    add("t1_idle",       NONE,         3, 8'b0000_0000, 3);
    add("idle_sync_ign", SYNC,         3, 8'b0000_0000, 3);
    // T4: swap in IDLE toggles next cycle
    add("t4_idle_swap",  SWAP,         3, 8'b0001_1000, 3);
    add("t4_idle_after", NONE,         3, 8'b0001_0000, 3);
    // T3 + T4: looping run, swaps deferred to boundary, graceful stop
    add("t3_start",      START|LOOP,   3, 8'b1011_0010, 0);
    add("t3_pulse_end",  LOOP,         3, 8'b1001_0010, 0);
    add("t3_done_run",   DONE|LOOP,    3, 8'b0101_0010, 0);
    add("t3_sync1",      SYNC|LOOP,    3, 8'b0101_0110, 1);
    add("t4_run_swap1",  SWAP|LOOP,    3, 8'b0101_0010, 1);
    add("t4_run_swap2",  SWAP|LOOP,    3, 8'b0101_0010, 1);
    add("t4_sync_toggle",SYNC|LOOP,    3, 8'b0100_1110, 2);
    add("t4_swap_w_sync",SYNC|SWAP|LOOP,3,8'b0101_1110, 3);
    add("t3_stop",       STOP|LOOP,    3, 8'b0101_0010, 3);
    add("t3_hold_run",   LOOP,         3, 8'b0101_0010, 3);
    add("t3_sync_exit",  SYNC|LOOP,    3, 8'b0001_0100, 4);
    add("t3_idle",       LOOP,         3, 8'b0001_0000, 4);
    // T5: cmdInit abort in RUN, coincident sync is not a frame
    add("t5_start",      START|LOOP,   3, 8'b1011_0010, 0);
    add("t5_pulse_end",  LOOP,         3, 8'b1001_0010, 0);
    add("t5_done_run",   DONE|LOOP,    3, 8'b0101_0010, 0);
    add("t5_abort",      INIT|SYNC|LOOP,3,8'b1011_0010, 0);
    add("t5_wait",       SYNC|LOOP,    3, 8'b1001_0010, 0);
    add("t5_done_idle",  DONE|LOOP,    3, 8'b0001_0000, 0);
    // T6: start+stop in IDLE
    add("t6_start_stop", START|STOP,   3, 8'b0001_0000, 0);
    add("t6_idle",       NONE,         3, 8'b0001_0000, 0);
    // cfgFrames=0 with cfgLoop=0 runs until stopped
    add("f0_start",      START,        0, 8'b1011_0010, 0);
    add("f0_pulse_end",  NONE,         0, 8'b1001_0010, 0);
    add("f0_done_run",   DONE,         0, 8'b0101_0010, 0);
    add("f0_sync1",      SYNC,         0, 8'b0101_0110, 1);
    add("f0_sync2",      SYNC,         0, 8'b0101_0110, 2);
    add("f0_stop",       STOP,         0, 8'b0101_0010, 2);
    add("f0_sync_exit",  SYNC,         0, 8'b0001_0100, 3);

    syncReset = 1'b1;
    apply(NONE, 8'd0);
    apply(NONE, 8'd0);
    check("reset_outputs", {outs(), bus.frameCount}, 16'h0000);
    syncReset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].in, vecs[i].frames);
      check(vecs[i].name, {outs(), bus.frameCount}, {vecs[i].exp, vecs[i].exp_cnt});
    end

    // T2: init timeout
    apply(START, 8'd3);
    pulses = int'(bus.initSlow);
    ran    = int'(bus.regCtrlRun);
    n      = 0;
    while (!bus.errInit && n < 40) begin
      apply(NONE, 8'd3);
      n++;
      pulses += int'(bus.initSlow);
      ran    |= int'(bus.regCtrlRun);
    end
    check("t2_timeout_cycles", n, TO + 1);
    check("t2_initslow_pulses", pulses, 1);
    check("t2_run_never", ran, 0);
    check("t2_idle_err", {bus.busy, bus.regCtrlInit, bus.errInit}, 3'b001);
    apply(NONE, 8'd3);
    check("t2_err_sticky", int'(bus.errInit), 1);
    apply(START, 8'd3);
    check("t2_start_clears_err", {bus.errInit, bus.regCtrlInit}, 2'b01);

    // T6: syncReset while running
    apply(NONE, 8'd3);
    apply(NONE, 8'd3);
    apply(DONE, 8'd3);
    check("t6_run_before_rst", int'(bus.regCtrlRun), 1);
    syncReset = 1'b1;
    apply(NONE, 8'd3);
    check("t6_reset_in_run", {outs(), bus.frameCount}, 16'h0000);
    syncReset = 1'b0;
    apply(SYNC, 8'd3);
    check("t6_post_reset_idle", {outs(), bus.frameCount}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
